// File: rtl/arilla_arb_pkg.sv
// Shared types for the arilla core/debug bus arbiter.
// ARILLA_ARB_TIMEOUT_EN adds the TIMEOUT state used by the grant watchdog.
package arilla_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGntCore = 2'd1,
        StGntDbg  = 2'd2
`ifdef ARILLA_ARB_TIMEOUT_EN
        , StTimeout = 2'd3
`endif
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } arb_req_t;

    localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/arilla_arb_timer.sv
// Grant watchdog: counts grant cycles without s_ready and flags the cycle the
// count reaches TimeoutCycles. Only instantiated with ARILLA_ARB_TIMEOUT_EN.
module arilla_arb_timer
    import arilla_arb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires in the cycle whose increment lands on the limit.
    assign o_expire = i_inc && (({1'b0, r_cnt} + 9'd1) == 9'(TimeoutCycles));

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Two-master (core, debug) arbiter onto a single slave port.
// ARILLA_ARB_TIMEOUT_EN enables the grant timeout and the err outputs.
module arilla_bus_arbiter
    import arilla_arb_pkg::*;
#(
    parameter int unsigned DebugPriority = 1,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_addr,
    input  logic        c_rd,
    input  logic        c_wr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wmask,
    output logic [31:0] c_rdata,
    output logic        c_done,
    output logic        c_err,
    input  logic [31:0] d_addr,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] s_addr,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        grant_dbg
);

    arb_state_e r_state, w_state_next;
    owner_e     r_last, w_last_next;
    arb_req_t   w_c_req, w_d_req, w_own_req;
    logic       w_c_act, w_d_act, w_gnt;

    assign w_c_req = '{addr: c_addr, rd: c_rd, wr: c_wr, wdata: c_wdata, wmask: c_wmask};
    assign w_d_req = '{addr: d_addr, rd: d_rd, wr: d_wr, wdata: d_wdata, wmask: d_wmask};
    assign w_c_act = c_rd | c_wr;
    assign w_d_act = d_rd | d_wr;
    assign w_gnt   = (r_state == StGntCore) || (r_state == StGntDbg);
    // r_last always names the current owner once a grant has been entered.
    assign w_own_req = (r_last == OWN_DBG) ? w_d_req : w_c_req;

`ifdef ARILLA_ARB_TIMEOUT_EN
    logic w_expire, w_tmr_clear, w_tmr_inc;

    assign w_tmr_clear = !w_gnt;
    assign w_tmr_inc   = w_gnt && !s_ready;

    arilla_arb_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmr_clear),
        .i_inc    (w_tmr_inc),
        .o_expire (w_expire)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_last  <= OWN_CORE;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            StIdle: begin
                if (w_d_act && (!w_c_act || DebugPriority != 0 || r_last == OWN_CORE)) begin
                    w_state_next = StGntDbg;
                    w_last_next  = OWN_DBG;
                end else if (w_c_act) begin
                    w_state_next = StGntCore;
                    w_last_next  = OWN_CORE;
                end
            end
            StGntCore, StGntDbg: begin
                if (s_ready) begin
                    w_state_next = StIdle;
`ifdef ARILLA_ARB_TIMEOUT_EN
                end else if (w_expire) begin
                    w_state_next = StTimeout;
`endif
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        s_addr    = '0;
        s_rd      = 1'b0;
        s_wr      = 1'b0;
        s_wdata   = '0;
        s_wmask   = '0;
        c_rdata   = '0;
        c_done    = 1'b0;
        c_err     = 1'b0;
        d_rdata   = '0;
        d_done    = 1'b0;
        d_err     = 1'b0;
        grant_dbg = 1'b0;
        if (!rst) begin
            if (w_gnt) begin
                s_addr  = w_own_req.addr;
                s_wr    = w_own_req.wr;
                s_rd    = w_own_req.rd & ~w_own_req.wr;
                s_wdata = w_own_req.wdata;
                s_wmask = w_own_req.wmask;
                if (s_ready) begin
                    if (r_last == OWN_DBG) begin
                        d_done  = 1'b1;
                        d_rdata = s_rdata;
                    end else begin
                        c_done  = 1'b1;
                        c_rdata = s_rdata;
                    end
                end
            end
`ifdef ARILLA_ARB_TIMEOUT_EN
            if (r_state == StTimeout) begin
                if (r_last == OWN_DBG) begin
                    d_done = 1'b1;
                    d_err  = 1'b1;
                end else begin
                    c_done = 1'b1;
                    c_err  = 1'b1;
                end
            end
`endif
            grant_dbg = (r_state != StIdle) && (r_last == OWN_DBG);
        end
    end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Scoreboard bench for arilla_bus_arbiter; timeout checks apply when
// ARILLA_ARB_TIMEOUT_EN is defined.
module tb_arilla_bus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          drop;
        bit          to;
    } tb_req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } tb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_rr;
    logic [31:0] m_addr  [2];
    logic        m_rd    [2];
    logic        m_wr    [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];
    logic [31:0] s_rdata;
    logic        s_ready;

    logic [31:0] a_c_rdata, a_d_rdata, a_s_addr, a_s_wdata;
    logic        a_c_done, a_c_err, a_d_done, a_d_err, a_s_rd, a_s_wr, a_gdbg;
    logic [3:0]  a_s_wmask;
    logic [31:0] b_c_rdata, b_d_rdata, b_s_addr, b_s_wdata;
    logic        b_c_done, b_c_err, b_d_done, b_d_err, b_s_rd, b_s_wr, b_gdbg;
    logic [3:0]  b_s_wmask;

    logic [1:0]  sel_done, sel_err;
    logic [31:0] sel_rdata [2];
    logic [31:0] sel_s_addr, sel_s_wdata;
    logic        sel_s_rd, sel_s_wr, sel_gdbg, sel_act;
    logic [3:0]  sel_s_wmask;
    logic [138:0] sel_outs;

    tb_req_t req_q [2][$];
    tb_exp_t exp_q [2][$];
    int      ord_q [$];
    tb_req_t cur   [2];
    bit      act   [2];
    int      age   [2];
    int      slave_lat;
    int      n_tests = 0;
    int      n_fail  = 0;
    int      n;

    always #5 clk = ~clk;

    arilla_bus_arbiter #(.DebugPriority(1), .TimeoutCycles(4)) u_dut (
        .clk(clk), .rst(rst),
        .c_addr(m_addr[0]), .c_rd(m_rd[0]), .c_wr(m_wr[0]), .c_wdata(m_wdata[0]),
        .c_wmask(m_wmask[0]), .c_rdata(a_c_rdata), .c_done(a_c_done), .c_err(a_c_err),
        .d_addr(m_addr[1]), .d_rd(m_rd[1]), .d_wr(m_wr[1]), .d_wdata(m_wdata[1]),
        .d_wmask(m_wmask[1]), .d_rdata(a_d_rdata), .d_done(a_d_done), .d_err(a_d_err),
        .s_addr(a_s_addr), .s_rd(a_s_rd), .s_wr(a_s_wr), .s_wdata(a_s_wdata),
        .s_wmask(a_s_wmask), .s_rdata(s_rdata), .s_ready(s_ready), .grant_dbg(a_gdbg)
    );

    arilla_bus_arbiter #(.DebugPriority(0), .TimeoutCycles(4)) u_dut_rr (
        .clk(clk), .rst(rst),
        .c_addr(m_addr[0]), .c_rd(m_rd[0]), .c_wr(m_wr[0]), .c_wdata(m_wdata[0]),
        .c_wmask(m_wmask[0]), .c_rdata(b_c_rdata), .c_done(b_c_done), .c_err(b_c_err),
        .d_addr(m_addr[1]), .d_rd(m_rd[1]), .d_wr(m_wr[1]), .d_wdata(m_wdata[1]),
        .d_wmask(m_wmask[1]), .d_rdata(b_d_rdata), .d_done(b_d_done), .d_err(b_d_err),
        .s_addr(b_s_addr), .s_rd(b_s_rd), .s_wr(b_s_wr), .s_wdata(b_s_wdata),
        .s_wmask(b_s_wmask), .s_rdata(s_rdata), .s_ready(s_ready), .grant_dbg(b_gdbg)
    );

    assign sel_done     = sel_rr ? {b_d_done, b_c_done} : {a_d_done, a_c_done};
    assign sel_err      = sel_rr ? {b_d_err, b_c_err} : {a_d_err, a_c_err};
    assign sel_rdata[0] = sel_rr ? b_c_rdata : a_c_rdata;
    assign sel_rdata[1] = sel_rr ? b_d_rdata : a_d_rdata;
    assign sel_s_addr   = sel_rr ? b_s_addr : a_s_addr;
    assign sel_s_wdata  = sel_rr ? b_s_wdata : a_s_wdata;
    assign sel_s_wmask  = sel_rr ? b_s_wmask : a_s_wmask;
    assign sel_s_rd     = sel_rr ? b_s_rd : a_s_rd;
    assign sel_s_wr     = sel_rr ? b_s_wr : a_s_wr;
    assign sel_gdbg     = sel_rr ? b_gdbg : a_gdbg;
    assign sel_act      = sel_s_rd | sel_s_wr;
    assign sel_outs     = {sel_rdata[0], sel_rdata[1], sel_done, sel_err, sel_s_addr,
                           sel_s_rd, sel_s_wr, sel_s_wdata, sel_s_wmask, sel_gdbg};

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    function automatic tb_req_t mk(input logic [31:0] a, input logic rd, input logic wr,
                                   input logic [31:0] wd, input logic [3:0] wm,
                                   input bit drop, input bit to);
        tb_req_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.wdata = wd; r.wmask = wm;
        r.drop = drop; r.to = to;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Master drivers: hold each request until its done (or reset), then load the next.
    initial begin
        bit fin [2];
        tb_exp_t e;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_rd[m] = 1'b0; m_wr[m] = 1'b0;
            m_wdata[m] = '0; m_wmask[m] = '0; act[m] = 1'b0; age[m] = 0;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) fin[m] = rst || sel_done[m];
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (fin[m] || !act[m]) begin
                    if (!rst && req_q[m].size() > 0) begin
                        cur[m] = req_q[m].pop_front();
                        m_addr[m] = cur[m].addr; m_rd[m] = cur[m].rd; m_wr[m] = cur[m].wr;
                        m_wdata[m] = cur[m].wdata; m_wmask[m] = cur[m].wmask;
                        act[m] = 1'b1; age[m] = 0;
                        e.rdata = cur[m].to ? 32'h0 : rdata_of(cur[m].addr);
                        e.err   = cur[m].to;
                        exp_q[m].push_back(e);
                    end else begin
                        m_addr[m] = '0; m_rd[m] = 1'b0; m_wr[m] = 1'b0;
                        m_wdata[m] = '0; m_wmask[m] = '0; act[m] = 1'b0;
                    end
                end else begin
                    age[m]++;
                    if (cur[m].drop && age[m] >= 2) begin
                        m_rd[m] = 1'b0; m_wr[m] = 1'b0;
                    end
                end
            end
        end
    end

    // Slave: once it sees a request it answers slave_lat cycles later (0 = never).
    initial begin
        bit          eng = 1'b0;
        bit          nxt = 1'b0;
        int          cnt = 0;
        logic [31:0] addr_l = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || s_ready) begin
                eng = 1'b0; cnt = 0; nxt = 1'b0;
            end else if (eng || sel_act) begin
                if (sel_act) addr_l = sel_s_addr;
                eng = 1'b1;
                cnt++;
                nxt = (slave_lat > 0) && (cnt >= slave_lat);
            end else begin
                nxt = 1'b0;
            end
            @(posedge clk);
            #1;
            s_ready = nxt;
            s_rdata = nxt ? rdata_of(addr_l) : 32'h0;
        end
    end

    // Scoreboard: every done pops the owner's expected result and the expected grant order.
    initial begin
        tb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q[0].delete();
                exp_q[1].delete();
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (sel_done[m]) begin
                        check_eq("other_done", {31'd0, sel_done[1-m]}, 32'd0);
                        check_eq("other_rdata", sel_rdata[1-m], 32'd0);
                        check_eq("other_err", {31'd0, sel_err[1-m]}, 32'd0);
                        if (exp_q[m].size() == 0) begin
                            check_eq("unexpected_done", exp_q[m].size(), 1);
                        end else begin
                            e = exp_q[m].pop_front();
                            check_eq(m == 0 ? "c_rdata" : "d_rdata", sel_rdata[m], e.rdata);
                            check_eq(m == 0 ? "c_err" : "d_err", {31'd0, sel_err[m]},
                                     {31'd0, e.err});
                        end
                        if (ord_q.size() > 0) check_eq("grant_order", m, ord_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check_eq("rst_outs", $countones(sel_outs), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called at a negedge right after queueing: request drives s_* two negedges later.
    task automatic wait_req(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sel_act && k < 20);
        check_eq(tag, k, 2);
    endtask

    task automatic wait_drain(input int bound);
        int pend = 1;
        for (int i = 0; i < bound && pend != 0; i++) begin
            @(negedge clk);
            pend = req_q[0].size() + req_q[1].size() + exp_q[0].size() + exp_q[1].size()
                   + int'(act[0]) + int'(act[1]);
        end
        check_eq("drain", pend, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sel_rr = 1'b0;
        slave_lat = 1;
        do_reset(3);

        // Core read with a one-cycle slave.
        @(negedge clk);
        req_q[0].push_back(mk(32'h100, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        ord_q.push_back(0);
        wait_req("c_rd_lat");
        check_eq("c_rd_srd", {31'd0, sel_s_rd}, 32'd1);
        check_eq("c_rd_addr", sel_s_addr, 32'h100);
        check_eq("c_rd_gdbg", {31'd0, sel_gdbg}, 32'd0);
        wait_drain(20);

        // rd and wr together go out as a write.
        req_q[0].push_back(mk(32'h200, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0));
        wait_req("rmw_lat");
        check_eq("rmw_swr", {31'd0, sel_s_wr}, 32'd1);
        check_eq("rmw_srd", {31'd0, sel_s_rd}, 32'd0);
        check_eq("rmw_wmask", {28'd0, sel_s_wmask}, 32'hF);
        check_eq("rmw_wdata", sel_s_wdata, 32'h1234_5678);
        wait_drain(20);

        // Simultaneous requests, debug has priority; one idle cycle before core.
        req_q[1].push_back(mk(32'h300, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        req_q[0].push_back(mk(32'h400, 1'b0, 1'b1, 32'hCAFE_0001, 4'h3, 1'b0, 1'b0));
        ord_q.push_back(1);
        ord_q.push_back(0);
        wait_req("prio_lat");
        check_eq("prio_gdbg", {31'd0, sel_gdbg}, 32'd1);
        check_eq("prio_addr", sel_s_addr, 32'h300);
        @(negedge clk);
        @(negedge clk);
        check_eq("gap_idle", {31'd0, sel_act}, 32'd0);
        @(negedge clk);
        check_eq("core_swr", {31'd0, sel_s_wr}, 32'd1);
        check_eq("core_addr", sel_s_addr, 32'h400);
        check_eq("core_wmask", {28'd0, sel_s_wmask}, 32'h3);
        check_eq("core_gdbg", {31'd0, sel_gdbg}, 32'd0);
        wait_drain(20);

        // Owner drops its strobes mid-grant: grant holds and done still arrives.
        slave_lat = 2;
        req_q[1].push_back(mk(32'h600, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0));
        wait_req("drop_lat");
        @(negedge clk);
        check_eq("drop_mirror", {31'd0, sel_s_rd}, 32'd0);
        check_eq("drop_hold", {31'd0, sel_gdbg}, 32'd1);
        wait_drain(20);

        // Round-robin instance, both masters requesting back to back.
        sel_rr = 1'b1;
        slave_lat = 1;
        do_reset(2);
        @(negedge clk);
        req_q[0].push_back(mk(32'h800, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        req_q[0].push_back(mk(32'h804, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        req_q[1].push_back(mk(32'h900, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        req_q[1].push_back(mk(32'h904, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) ord_q.push_back((i % 2 == 0) ? 1 : 0);
        wait_drain(60);
        sel_rr = 1'b0;
        do_reset(2);

`ifdef ARILLA_ARB_TIMEOUT_EN
        // Slave never answers: four grant cycles, then one timeout cycle.
        slave_lat = 0;
        @(negedge clk);
        req_q[1].push_back(mk(32'hA00, 1'b0, 1'b1, 32'h55, 4'hF, 1'b0, 1'b1));
        wait_req("to_lat");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("to_hold_swr", {31'd0, sel_s_wr}, 32'd1);
            check_eq("to_hold_done", {31'd0, sel_done[1]}, 32'd0);
        end
        @(negedge clk);
        check_eq("to_swr", {31'd0, sel_s_wr}, 32'd0);
        check_eq("to_done", {31'd0, sel_done[1]}, 32'd1);
        check_eq("to_err", {31'd0, sel_err[1]}, 32'd1);
        @(negedge clk);
        check_eq("to_pulse", {31'd0, sel_done[1]}, 32'd0);
        do_reset(2);
        // s_ready in the limit cycle completes normally.
        slave_lat = 3;
        @(negedge clk);
        req_q[1].push_back(mk(32'hB00, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        wait_drain(20);
`else
        // No timeout: the grant waits on the slave indefinitely.
        slave_lat = 0;
        @(negedge clk);
        req_q[1].push_back(mk(32'hA00, 1'b0, 1'b1, 32'h55, 4'hF, 1'b0, 1'b0));
        wait_req("wait_lat");
        repeat (12) @(negedge clk);
        check_eq("wait_swr", {31'd0, sel_s_wr}, 32'd1);
        check_eq("wait_done", {31'd0, sel_done[1]}, 32'd0);
        check_eq("wait_err", {31'd0, sel_err[1]}, 32'd0);
        do_reset(2);
`endif

        // Reset mid-grant aborts silently; a fresh request then proceeds.
        slave_lat = 0;
        @(negedge clk);
        req_q[0].push_back(mk(32'h700, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        wait_req("abort_lat");
        do_reset(2);
        slave_lat = 1;
        @(negedge clk);
        req_q[0].push_back(mk(32'h704, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0));
        ord_q.push_back(0);
        wait_req("post_rst_lat");
        check_eq("post_rst_addr", sel_s_addr, 32'h704);
        wait_drain(20);
        check_eq("order_left", ord_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
